// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator and the logic that feeds it:
// op-code width and encodings, plus the fixed requester-id width.
package comparator_pkg;

    localparam int CMP_OP_W = 3;
    localparam int ID_W     = 2;   // up to four requesters

    typedef logic [CMP_OP_W-1:0] cmp_op_t;

    // All comparisons are unsigned; 110/111 are reserved and yield 0.
    localparam cmp_op_t CMP_EQ  = 3'b000;
    localparam cmp_op_t CMP_GE  = 3'b001;
    localparam cmp_op_t CMP_LE  = 3'b010;
    localparam cmp_op_t CMP_GT  = 3'b011;
    localparam cmp_op_t CMP_LT  = 3'b100;
    localparam cmp_op_t CMP_NE  = 3'b101;
    localparam cmp_op_t CMP_NOP = 3'b111;   // idle stage value, compares to 0

endpackage

// File: rtl/comparator_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the
// shared comparator arbiter. Packing: requester i at [i*WIDTH +: WIDTH].
interface comparator_arbiter_if
    import comparator_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32
);

    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*WIDTH-1:0]    req_a;
    logic [N_REQ*WIDTH-1:0]    req_b;
    logic [N_REQ*CMP_OP_W-1:0] req_op;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_result;
    logic                      rsp_ready;

    // Requesters and response consumer
    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/comparator.sv
// Unsigned WIDTH-bit comparator selected by a 3-bit op code.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  cmp_op_t          op,
    output logic             result
);

    // Evaluate the selected relation; reserved or unknown ops give 0.
    always_comb begin
        // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
        result = 1'b0;
        case (op)
            CMP_EQ:  result = (a == b);
            CMP_GE:  result = (a >= b);
            CMP_LE:  result = (a <= b);
            CMP_GT:  result = (a >  b);
            CMP_LT:  result = (a <  b);
            CMP_NE:  result = (a != b);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit searching cyclically
// from last+1. The pointer register lives in the caller.
module rr_arbiter
    import comparator_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    grant_onehot,
    output logic [ID_W-1:0] grant_idx
);

    int   idx;
    logic found;

    // Walk the N positions after last, taking the first requester seen.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/comparator_arbiter.sv
// Shares one comparator among N_REQ requesters: round-robin grant, a
// registered operand stage, and a single backpressured response channel.
module comparator_arbiter
    import comparator_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = 32
) (
    input logic                 clock,
    input logic                 reset,
    comparator_arbiter_if.slave bus
);

    logic [ID_W-1:0]  last_grant;
    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    cmp_op_t          stage_op;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;

    logic [N_REQ-1:0] grant_onehot;
    logic [ID_W-1:0]  grant_idx;
    logic             stall;
    logic             xfer;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req          (bus.req_valid),
        .last         (last_grant),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    // Accept only when the response slot can advance and not in reset.
    assign stall         = rsp_valid_q & ~bus.rsp_ready;
    assign bus.req_ready = grant_onehot & {N_REQ{~stall & ~reset}};
    assign xfer          = |bus.req_ready;

    // Latch the winner's operands and own the response; hold during stall.
    always_ff @(posedge clock) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            last_grant  <= ID_W'(N_REQ - 1);
            stage_a     <= '0;
            stage_b     <= '0;
            stage_op    <= CMP_NOP;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else if (xfer) begin
            stage_a     <= bus.req_a[grant_idx*WIDTH +: WIDTH];
            stage_b     <= bus.req_b[grant_idx*WIDTH +: WIDTH];
            stage_op    <= bus.req_op[grant_idx*CMP_OP_W +: CMP_OP_W];
            last_grant  <= grant_idx;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant_idx;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    comparator #(.WIDTH(WIDTH)) u_cmp (
        .a      (stage_a),
        .b      (stage_b),
        .op     (stage_op),
        .result (bus.rsp_result)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter with hand-computed expectations.
module tb_comparator_arbiter;
    import comparator_pkg::*;

    localparam int N_REQ = 2;
    localparam int WIDTH = 32;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    comparator_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    comparator_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Compare one observed value with its expectation and count it.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        bus.req_a[i*WIDTH +: WIDTH]       = a;
        bus.req_b[i*WIDTH +: WIDTH]       = b;
        bus.req_op[i*CMP_OP_W +: CMP_OP_W] = op;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [1:0] id, input logic r);
        check({tag, ".valid"},  32'(bus.rsp_valid),  32'(v));
        check({tag, ".id"},     32'(bus.rsp_id),     32'(id));
        check({tag, ".result"}, 32'(bus.rsp_result), 32'(r));
    endtask

    // Operator table against requester 0: {a, b, op, expected result}
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        res;
    } op_vec_t;

    op_vec_t ops [13];

    initial begin
        ops[0]  = '{32'hFFFF_FFFF, 32'h0, 3'b011, 1'b1};
        ops[1]  = '{32'hFFFF_FFFF, 32'h0, 3'b100, 1'b0};
        ops[2]  = '{32'hFFFF_FFFF, 32'h0, 3'b101, 1'b1};
        ops[3]  = '{32'hFFFF_FFFF, 32'h0, 3'b110, 1'b0};
        ops[4]  = '{32'hFFFF_FFFF, 32'h0, 3'b001, 1'b1};
        ops[5]  = '{32'hFFFF_FFFF, 32'h0, 3'bxxx, 1'b0};
        ops[6]  = '{32'hFFFF_FFFF, 32'h0, 3'b010, 1'b0};
        ops[7]  = '{32'h0000_0009, 32'h9, 3'b001, 1'b1};
        ops[8]  = '{32'hFFFF_FFFF, 32'h0, 3'b111, 1'b0};
        ops[9]  = '{32'h0000_0009, 32'h9, 3'b010, 1'b1};
        ops[10] = '{32'h0000_0009, 32'h9, 3'b101, 1'b0};
        ops[11] = '{32'h0000_0009, 32'h9, 3'b000, 1'b1};
        ops[12] = '{32'h0000_0009, 32'h9, 3'b011, 1'b0};

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;

        // Reset state; a valid request is not accepted while in reset
        tick();
        bus.req_valid = 2'b01;
        #1;
        check("reset.req_ready", 32'(bus.req_ready), 32'h0);
        tick();
        check_rsp("reset", 1'b0, 2'd0, 1'b0);

        // Single eq from requester 0
        reset = 1'b0;
        set_req(0, 32'd5, 32'd5, CMP_EQ);
        bus.req_valid = 2'b01;
        #1;
        check("eq.req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        check_rsp("eq", 1'b1, 2'd0, 1'b1);
        bus.req_valid = 2'b00;
        tick();
        check("eq.drain", 32'(bus.rsp_valid), 32'h0);

        // Alternation from reset: grants 0,1,0,1 with results 1,0,1,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 32'd3, 32'd7, CMP_LT);
        set_req(1, 32'd7, 32'd3, CMP_LE);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("alt%0d.req_ready", i), 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check_rsp($sformatf("alt%0d", i), 1'b1, 2'(i % 2), (i % 2 == 0));
        end

        // Backpressure: three stalled cycles, then requester 0 resumes
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.req_ready", i), 32'(bus.req_ready), 32'h0);
            tick();
            check_rsp($sformatf("bp%0d", i), 1'b1, 2'd1, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp.resume.req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        check_rsp("bp.resume", 1'b1, 2'd0, 1'b1);

        // Lone requester 1 is granted every cycle
        bus.req_valid = 2'b10;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("solo%0d.req_ready", i), 32'(bus.req_ready), 32'h2);
            tick();
            check_rsp($sformatf("solo%0d", i), 1'b1, 2'd1, 1'b0);
        end

        // Unsigned, equal-operand and reserved ops through requester 0
        bus.req_valid = 2'b01;
        for (int i = 0; i < 13; i++) begin
            set_req(0, ops[i].a, ops[i].b, ops[i].op);
            #1;
            check($sformatf("op%0d.req_ready", i), 32'(bus.req_ready), 32'h1);
            tick();
            check_rsp($sformatf("op%0d", i), 1'b1, 2'd0, ops[i].res);
        end

        // Reset while a response is stalled
        set_req(0, 32'hFFFF_FFFF, 32'h0, CMP_GT);
        tick();
        check_rsp("rst.pre", 1'b1, 2'd0, 1'b1);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b11;
        tick();
        check_rsp("rst.stall", 1'b1, 2'd0, 1'b1);
        reset = 1'b1;
        #1;
        check("rst.req_ready", 32'(bus.req_ready), 32'h0);
        tick();
        reset = 1'b0;
        check_rsp("rst.post", 1'b0, 2'd0, 1'b0);
        #1;
        check("rst.first_grant", 32'(bus.req_ready), 32'h1);
        tick();
        check_rsp("rst.first", 1'b1, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/comparator_arbiter.md
# comparator_arbiter

Shares one `Comparator` (32-bit operands, 3-bit op, 1-bit result) among `N_REQ` requesters, e.g. branch-resolve and set-on-compare units. Round-robin arbitration, a registered operand stage feeding the `Comparator`, and a single response channel with backpressure. Throughput is one compare per cycle; latency is one cycle from acceptance to response.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters (2..4).
- `WIDTH`, default 32: operand width.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: requester i has a compare pending.
- `req_ready` out N_REQ: requester i is accepted this cycle; at most one bit set.
- `req_a` in N_REQ*WIDTH: operand A, requester i at bits [i*WIDTH +: WIDTH].
- `req_b` in N_REQ*WIDTH: operand B, same packing.
- `req_op` in N_REQ*3: op code, requester i at bits [i*3 +: 3].
- `rsp_valid` out 1: response present.
- `rsp_id` out 2: index of the requester owning the response.
- `rsp_result` out 1: `Comparator` output for the accepted transaction.
- `rsp_ready` in 1: consumer takes the response.

## Operation
- Op codes, all unsigned:
  - 000: a==b
  - 001: a>=b
  - 010: a<=b
  - 011: a>b
  - 100: a<b
  - 101: a!=b
  - 110, 111 and any op with x/z bits: result 0.
- Round-robin pointer `last_grant`. The winner is the first i with `req_valid[i]`, searching cyclically from `last_grant+1`.
- `stall = rsp_valid & ~rsp_ready`.
- `req_ready = winner_onehot & ~stall & ~reset`.
- Transfer happens when `req_valid[i] & req_ready[i]`. On transfer:
  - the winner's a/b/op latch into the stage register;
  - `last_grant` becomes the winner;
  - `rsp_valid` becomes 1 and `rsp_id` becomes the winner.
- The `Comparator` is driven combinationally from the stage register. `rsp_result` is its output and is stable while the stage is held.
- When `rsp_valid & rsp_ready` and there is no new transfer, `rsp_valid` goes to 0 next cycle.
- When there is a new transfer and `rsp_ready` is high, the response is replaced back-to-back with no bubble.
- During a stall:
  - the stage register, `rsp_*` and `last_grant` hold;
  - no `req_ready` is asserted.
- A requester must hold `req_valid` and its operands until accepted. Dropping `req_valid` before acceptance is legal and the request is withdrawn.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0 (stage register cleared, op=111);
  - `req_ready`=0;
  - `last_grant`=N_REQ-1, so requester 0 wins first.
- Latency: transfer at edge T, so `rsp_valid`/`rsp_result` are valid in cycle T..T+1 (the first cycle after edge T).
- `req_ready` is combinational from `req_valid`, `rsp_valid` and `rsp_ready`. There is no combinational path from `req_a`/`req_b` to any output.
- With a single requester valid every cycle, that requester is granted every cycle. Idle requesters cost no cycles.
- Reset mid-operation: a stalled or pending response is dropped; all state returns to reset values at the next edge.

## Structure
- Package `comparator_pkg`:
  - `CMP_OP_W`=3;
  - localparams `CMP_EQ`, `CMP_GE`, `CMP_LE`, `CMP_GT`, `CMP_LT`, `CMP_NE`.
  - The `Comparator` and its benches use the same package.
- Sub-module `rr_arbiter` (params `N`; inputs `req`, `last`; output `grant_onehot`, `grant_idx`). It is purely combinational; the pointer register stays in the top level.
- One `Comparator` instance is fed from the stage register.

## Test plan
- **Single eq:** requester 0 issues a=5, b=5, op=000 → `req_ready[0]`=1 that cycle; next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=1.
- **Alternation:** after reset, both requesters are valid continuously with `rsp_ready`=1. Requester 0 sends a=3, b=7, op=100; requester 1 sends a=7, b=3, op=010. Required: grants alternate 0,1,0,1, one per cycle; `rsp_id` alternates; results alternate 1,0.
- **Backpressure:** `rsp_ready`=0 for 3 cycles with both requesters valid → `rsp_*` hold stable, `req_ready`=0, `last_grant` unchanged. `rsp_ready`=1 → the other requester is accepted the same cycle.
- **Unsigned and illegal ops:**
  - a=32'hFFFFFFFF, b=0, op=011 → 1;
  - same operands, op=100 → 0;
  - op=110 → 0; op=3'bxxx → 0.
- **Reset mid-stall:** `reset`=1 for one cycle while `rsp_valid`=1 and `rsp_ready`=0 → next cycle `rsp_valid`=0, `rsp_result`=0; with both requesters valid, requester 0 is granted first.
